// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - stack command/operand bus between calc_sequencer and the stack
interface calc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             stk_req;
  logic [2:0]       stk_op;
  logic [WIDTH-1:0] stk_data;
  logic             stk_ack;
  logic [WIDTH-1:0] stk_top;
  logic [WIDTH-1:0] stk_next;
  logic [3:0]       stk_count;

  modport master (
    output stk_req, stk_op, stk_data,
    input  stk_ack, stk_top, stk_next, stk_count
  );

  modport slave (
    input  stk_req, stk_op, stk_data,
    output stk_ack, stk_top, stk_next, stk_count
  );
endinterface

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - numpad key sequencer issuing stack commands (macro CALC_MUL_EN: key D = multiply)
module calc_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        key_code,
  calc_sequencer_if.master  stk,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_WRITE     = 3'd1;
  localparam logic [2:0] OP_PUSH      = 3'd2;
  localparam logic [2:0] OP_POP_WRITE = 3'd3;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

`ifdef CALC_MUL_EN
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2,
    CALC   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2
  } state_t;
`endif

  state_t           state;
  logic [4:0]       prev_key;
  logic             armed;
  logic [3:0]       key_reg;
  logic             req_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;

  logic             key_event;
  logic [3:0]       digit;
  logic             is_digit;
  logic [WIDTH+3:0] dig_full;
  logic             two_plus;
  logic             dec_issue;
  logic             dec_err;
  logic [2:0]       dec_op;
  logic [WIDTH-1:0] dec_data;

`ifdef CALC_MUL_EN
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_acc;
  logic [CNT_W-1:0] mul_cnt;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic             dec_mul;
`endif

  assign stk.stk_req  = req_q;
  assign stk.stk_op   = op_q;
  assign stk.stk_data = data_q;

  // A press fires only on a change to a new pressed code; armed stays low for
  // the first cycle after reset so a key held through reset is absorbed.
  assign key_event = armed && key_code[4] && (key_code != prev_key);
  assign two_plus  = (stk.stk_count >= 4'd2);

  // Map the latched key index onto a digit value.
  always_comb begin
    digit    = 4'd0;
    is_digit = 1'b1;
    case (key_reg)
      4'h0:    digit = 4'd1;
      4'h1:    digit = 4'd4;
      4'h2:    digit = 4'd7;
      4'h3:    digit = 4'd0;
      4'h4:    digit = 4'd2;
      4'h5:    digit = 4'd5;
      4'h6:    digit = 4'd8;
      4'h8:    digit = 4'd3;
      4'h9:    digit = 4'd6;
      4'hA:    digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  // Digit entry result kept four bits wider so overflow past WIDTH is visible.
  assign dig_full = {4'b0000, stk.stk_top} * (WIDTH+4)'(10) + (WIDTH+4)'(digit);

`ifdef CALC_MUL_EN
  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  assign mul_acc_nxt = mul_b[0] ? (mul_acc + mul_a) : mul_acc;
`endif

  // Decide the command (or error) for the latched key from the live stack operands.
  always_comb begin
    dec_issue = 1'b0;
    dec_err   = 1'b0;
    dec_op    = OP_NOP;
    dec_data  = '0;
`ifdef CALC_MUL_EN
    dec_mul   = 1'b0;
`endif
    if (is_digit) begin
      if (|dig_full[WIDTH+3:WIDTH]) begin
        dec_err = 1'b1;
      end else begin
        dec_issue = 1'b1;
        dec_op    = OP_WRITE;
        dec_data  = dig_full[WIDTH-1:0];
      end
    end else begin
      case (key_reg)
        4'hC: begin
          if (stk.stk_count < DEPTH_C) begin
            dec_issue = 1'b1;
            dec_op    = OP_PUSH;
          end else begin
            dec_err = 1'b1;
          end
        end
        4'hD: begin
          if (two_plus) begin
            dec_issue = 1'b1;
            dec_op    = OP_POP_WRITE;
            dec_data  = stk.stk_next + stk.stk_top;
          end else begin
            dec_err = 1'b1;
          end
        end
        4'hE: begin
          if (two_plus) begin
            dec_issue = 1'b1;
            dec_op    = OP_POP_WRITE;
            dec_data  = stk.stk_next - stk.stk_top;
          end else begin
            dec_err = 1'b1;
          end
        end
        4'hB: begin
          dec_issue = 1'b1;
          if (two_plus) begin
            dec_op   = OP_POP_WRITE;
            dec_data = stk.stk_next;
          end else begin
            dec_op = OP_WRITE;
          end
        end
        4'hF: begin
`ifdef CALC_MUL_EN
          if (two_plus) begin
            dec_mul = 1'b1;
          end else begin
            dec_err = 1'b1;
          end
`else
          dec_issue = 1'b1;
          dec_op    = OP_WRITE;
`endif
        end
        default: ;
      endcase
    end
  end

  // Main sequencer: key capture, decode, optional multiply, command handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      prev_key <= 5'b00000;
      armed    <= 1'b0;
      key_reg  <= 4'd0;
      req_q    <= 1'b0;
      op_q     <= OP_NOP;
      data_q   <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
`ifdef CALC_MUL_EN
      mul_a    <= '0;
      mul_b    <= '0;
      mul_acc  <= '0;
      mul_cnt  <= '0;
`endif
    end else begin
      prev_key <= key_code;
      armed    <= 1'b1;
      case (state)
        IDLE: begin
          if (key_event) begin
            key_reg <= key_code[3:0];
            state   <= DECODE;
            busy    <= 1'b1;
          end
        end
        DECODE: begin
`ifdef CALC_MUL_EN
          if (dec_mul) begin
            mul_a   <= stk.stk_next;
            mul_b   <= stk.stk_top;
            mul_acc <= '0;
            mul_cnt <= '0;
            state   <= CALC;
          end else
`endif
          if (dec_issue) begin
            req_q  <= 1'b1;
            op_q   <= dec_op;
            data_q <= dec_data;
            err    <= 1'b0;
            state  <= ISSUE;
          end else begin
            err   <= err | dec_err;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
`ifdef CALC_MUL_EN
        CALC: begin
          mul_acc <= mul_acc_nxt;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == LAST_ITER) begin
            req_q  <= 1'b1;
            op_q   <= OP_POP_WRITE;
            data_q <= mul_acc_nxt;
            err    <= 1'b0;
            state  <= ISSUE;
          end
        end
`endif
        ISSUE: begin
          if (stk.stk_ack) begin
            req_q  <= 1'b0;
            op_q   <= OP_NOP;
            data_q <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          op_q  <= OP_NOP;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  key_code;
  logic        busy;
  logic        err;

  logic [31:0] top_v;
  logic [31:0] next_v;
  logic [3:0]  cnt_v;

  int n_chk = 0;
  int n_err = 0;

  calc_sequencer_if #(.WIDTH(32)) sif ();

  assign sif.stk_top   = top_v;
  assign sif.stk_next  = next_v;
  assign sif.stk_count = cnt_v;

  calc_sequencer #(.WIDTH(32), .DEPTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .key_code (key_code),
    .stk      (sif),
    .busy     (busy),
    .err      (err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (!sif.stk_req && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    if (!sif.stk_req) check_eq("req_timeout", 64'(0), 64'(1));
  endtask

  // Press a key, expect one command, ack it, release, update the stack model.
  task automatic key_cmd(input string tag, input logic [4:0] k, input int exp_op,
                         input logic [31:0] exp_data, input int exp_lat);
    int lat;
    @(negedge clock);
    key_code = k;
    wait_req(lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_op"}, 64'(sif.stk_op), 64'(exp_op));
    check_eq({tag, "_data"}, 64'(sif.stk_data), 64'(exp_data));
    check_eq({tag, "_err"}, 64'(err), 64'(0));
    sif.stk_ack = 1'b1;
    @(negedge clock);
    sif.stk_ack = 1'b0;
    key_code = 5'b00000;
    check_eq({tag, "_idle"}, 64'({busy, sif.stk_req}), 64'(0));
    case (exp_op)
      1: top_v = exp_data;
      2: begin next_v = top_v; top_v = exp_data; cnt_v = cnt_v + 4'd1; end
      3: begin top_v = exp_data; cnt_v = cnt_v - 4'd1; next_v = 32'd0; end
      default: ;
    endcase
  endtask

  // Press a key that must not produce a command; busy drops after 2 cycles.
  task automatic key_nocmd(input string tag, input logic [4:0] k, input logic exp_err);
    logic seen;
    seen = 1'b0;
    @(negedge clock);
    key_code = k;
    repeat (2) begin
      @(negedge clock);
      if (sif.stk_req) seen = 1'b1;
    end
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
    repeat (3) begin
      @(negedge clock);
      if (sif.stk_req) seen = 1'b1;
    end
    key_code = 5'b00000;
    check_eq({tag, "_noreq"}, 64'(seen), 64'(0));
  endtask

  initial begin
    int fires;
    int lat;
    logic seen;

    reset       = 1'b1;
    key_code    = 5'b00000;
    sif.stk_ack = 1'b0;
    top_v       = 32'd0;
    next_v      = 32'd0;
    cnt_v       = 4'd1;
    repeat (3) @(negedge clock);
    check_eq("rst_req", 64'(sif.stk_req), 64'(0));
    check_eq("rst_op", 64'(sif.stk_op), 64'(0));
    check_eq("rst_data", 64'(sif.stk_data), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
    reset = 1'b0;

    // digit entry
    key_cmd("d1", 5'b10000, 1, 32'd1, 2);
    key_cmd("d2", 5'b10100, 1, 32'd12, 2);
    key_cmd("d3", 5'b11000, 1, 32'd123, 2);

    // push, digits 9 0 0, add
    key_cmd("push", 5'b11100, 2, 32'd0, 2);
    key_cmd("d9", 5'b11010, 1, 32'd9, 2);
    key_cmd("d0a", 5'b10011, 1, 32'd90, 2);
    key_cmd("d0b", 5'b10011, 1, 32'd900, 2);
    key_cmd("add", 5'b11101, 3, 32'd1023, 2);

    // subtract
    @(negedge clock);
    next_v = 32'd1023; top_v = 32'd8; cnt_v = 4'd2;
    key_cmd("sub", 5'b11110, 3, 32'd1015, 2);

    // held key 8 fires exactly once
    @(negedge clock);
    key_code = 5'b10110;
    fires = 0;
    repeat (100) begin
      @(negedge clock);
      if (sif.stk_ack) begin
        sif.stk_ack = 1'b0;
      end else if (sif.stk_req) begin
        fires++;
        check_eq("hold_data", 64'(sif.stk_data), 64'(10158));
        sif.stk_ack = 1'b1;
      end
    end
    sif.stk_ack = 1'b0;
    key_code = 5'b00000;
    check_eq("hold_fires", 64'(fires), 64'(1));
    top_v = 32'd10158;

    // delayed ack with outputs held; a new key during ISSUE is discarded
    @(negedge clock);
    key_code = 5'b10000;
    wait_req(lat);
    check_eq("dly_lat", 64'(lat), 64'(2));
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 1) key_code = 5'b10100;
      check_eq("dly_req", 64'(sif.stk_req), 64'(1));
      check_eq("dly_op", 64'(sif.stk_op), 64'(1));
      check_eq("dly_data", 64'(sif.stk_data), 64'(101581));
      check_eq("dly_busy", 64'(busy), 64'(1));
    end
    sif.stk_ack = 1'b1;
    @(negedge clock);
    sif.stk_ack = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (sif.stk_req) seen = 1'b1;
    end
    key_code = 5'b00000;
    check_eq("dly_discard", 64'(seen), 64'(0));
    top_v = 32'd101581;

    // underflow error, recovery, stack full
    @(negedge clock);
    top_v = 32'd0; cnt_v = 4'd1;
    key_nocmd("add_under", 5'b11101, 1'b1);
    key_nocmd("sub_under", 5'b11110, 1'b1);
    key_cmd("d5", 5'b10101, 1, 32'd5, 2);
    @(negedge clock);
    cnt_v = 4'd7;
    key_cmd("push7", 5'b11100, 2, 32'd0, 2);
    key_nocmd("push_full", 5'b11100, 1'b1);

    // drop with two entries and with one
    @(negedge clock);
    next_v = 32'd55; top_v = 32'd7; cnt_v = 4'd2;
    key_cmd("drop2", 5'b11011, 3, 32'd55, 2);
    key_cmd("drop1", 5'b11011, 1, 32'd0, 2);
    key_nocmd("ignored", 5'b10111, 1'b0);

    // wrap-around arithmetic
    @(negedge clock);
    next_v = 32'd3; top_v = 32'd5; cnt_v = 4'd2;
    key_cmd("sub_wrap", 5'b11110, 3, 32'hFFFF_FFFE, 2);
    @(negedge clock);
    next_v = 32'hFFFF_FFFF; top_v = 32'd2; cnt_v = 4'd2;
    key_cmd("add_wrap", 5'b11101, 3, 32'd1, 2);

    // digit overflow boundary
    @(negedge clock);
    top_v = 32'd429496729; cnt_v = 4'd1;
    key_nocmd("ovf6", 5'b11001, 1'b1);
    key_cmd("max5", 5'b10101, 1, 32'hFFFF_FFFF, 2);

    // key D
`ifdef CALC_MUL_EN
    @(negedge clock);
    next_v = 32'd1000; top_v = 32'd7; cnt_v = 4'd2;
    key_cmd("mul", 5'b11111, 3, 32'd7000, 34);
    key_nocmd("mul_under", 5'b11111, 1'b1);
`else
    @(negedge clock);
    top_v = 32'd77; cnt_v = 4'd1;
    key_cmd("keyd_clr", 5'b11111, 1, 32'd0, 2);
`endif

    // reset in ISSUE aborts; key held across reset does not fire
    @(negedge clock);
    top_v = 32'd0; cnt_v = 4'd1;
    key_code = 5'b10100;
    wait_req(lat);
    check_eq("ri_req", 64'(sif.stk_req), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    check_eq("ri_req0", 64'(sif.stk_req), 64'(0));
    check_eq("ri_busy0", 64'(busy), 64'(0));
    check_eq("ri_op0", 64'(sif.stk_op), 64'(0));
    check_eq("ri_err0", 64'(err), 64'(0));
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (sif.stk_req || busy) seen = 1'b1;
    end
    check_eq("ri_held", 64'(seen), 64'(0));
    key_code = 5'b00000;
    key_cmd("ri_repress", 5'b10100, 1, 32'd2, 2);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
